pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central pipeline stall/flush controller for the 5-stage MIPS core. It sits beside the EX-stage operand-forwarding unit and covers the hazards forwarding cannot resolve:
- load-use RAW between the ID and EX stages;
- multi-cycle divide occupancy in EX;
- data-cache wait in MEM (optional);
- exception flush.

It drives one per-stage stall vector, a flush, and a stall-cycle performance counter.

Parameters:
DIV_LATENCY, 32, cycles the divider needs after its start cycle (legal range 2..64).
CNT_W, $clog2(DIV_LATENCY), width of the divide countdown counter.

Ports:
clk_i  in  1  core clock
rst_ni  in  1  synchronous reset, active-low; one clock; reset is synchronous and active-low
id_re1_i  in  1  ID reads source register 1
id_raddr1_i  in  5  ID source register 1 address
id_re2_i  in  1  ID reads source register 2
id_raddr2_i  in  5  ID source register 2 address
ex_we_i  in  1  EX instruction writes a GPR
ex_waddr_i  in  5  EX destination register
ex_is_load_i  in  1  EX instruction is a load
ex_div_start_i  in  1  EX instruction is DIV/DIVU
flush_i  in  1  exception/ERET flush request from MEM
stall_o  out  6  stall mask: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
flush_o  out  1  flush all pipeline registers
div_busy_o  out  1  divide in progress
div_done_o  out  1  one-cycle pulse: divider result valid this cycle
stall_cnt_o  out  32  saturating count of cycles with stall_o != 0

Behaviour:
- Reset (rst_ni=0 at a clock edge): state=S_IDLE, cnt=0, stall_cnt_o=0.
- While rst_ni=0, all outputs are forced to 0.
- Stall masks, defined in the shared package:
  - LOAD_USE = 6'b000111
  - DIV = 6'b001111
  - MEM = 6'b011111
- Load-use hazard (combinational, same cycle): asserted when ex_is_load_i & ex_we_i & ex_waddr_i!=0 & ((id_re1_i & id_raddr1_i==ex_waddr_i) | (id_re2_i & id_raddr2_i==ex_waddr_i)).
  - Contributes LOAD_USE to the stall mask.
  - The ID/EX register inserts a bubble, so the hazard clears the next cycle (exactly 1 stall cycle).
- Divide FSM, states S_IDLE and S_DIV:
  - S_IDLE with ex_div_start_i=1: contribute DIV this cycle; next state S_DIV; cnt<=DIV_LATENCY-1.
  - S_DIV with cnt!=0: contribute DIV; cnt<=cnt-1; div_busy_o=1.
  - S_DIV with cnt==0: no DIV contribution; div_done_o=1; next state S_IDLE.
  - ex_div_start_i is ignored while in S_DIV; the held instruction keeps it asserted.
  - Result: DIV asserted for exactly DIV_LATENCY cycles; the EX instruction advances at the end of the done cycle.
  - div_busy_o = (state==S_DIV) | (state==S_IDLE & ex_div_start_i).
- stall_o = bitwise OR of all active contributions. The masks are nested, so the largest mask wins.
- flush_i has the highest priority. In the same cycle:
  - flush_o=1, stall_o=0, div_done_o=0;
  - next state S_IDLE and cnt<=0, which cancels any divide in progress.
- Simultaneous flush_i and ex_div_start_i: the divide does not start.
- stall_cnt_o increments by 1 on each cycle with stall_o!=0 and saturates at 32'hFFFF_FFFF. It is not cleared by flush.

Optional Feature:
PIPE_DCACHE_STALL_EN
- Defined: adds ports mem_req_i (in, 1: MEM stage has a data-cache access) and mem_ack_i (in, 1: access completes this cycle).
  - mem_req_i & ~mem_ack_i contributes MEM to the stall mask.
  - While MEM is active, the divide counter still decrements, because EX is frozen anyway.
  - Flush still overrides.
- Undefined: ports absent; no MEM contribution.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - stall_mask_t (logic [5:0]);
  - constants STALL_NONE/LOAD_USE/DIV/MEM;
  - stage index constants;
  - enum div_state_e {S_IDLE, S_DIV}.
- One natural sub-module: div_wait_fsm, containing the FSM and countdown. It outputs div_stall, div_busy and div_done, and has a cancel input.
- Load-use detection and mask combination stay in the top level.

Test Plan:
- Load-use: load to $5 in EX, ID reads $5 on re2 -> stall_o=000111 for exactly 1 cycle; same case with ex_waddr_i=0 -> stall_o=0.
- Divide, DIV_LATENCY=4: ex_div_start_i held from cycle T ->
  - stall_o=001111 for T..T+3;
  - div_done_o=1 only at T+4, with stall_o=0;
  - back-to-back DIV restarts at T+5.
- Flush at T+2 of a divide -> flush_o=1 and stall_o=0 that cycle; div_busy_o=0 at T+3; no div_done_o pulse.
- Load-use and DIV start in the same cycle -> stall_o=001111; stall_cnt_o increments once per stalled cycle.
- Under PIPE_DCACHE_STALL_EN: mem_req_i=1 with mem_ack_i low for 3 cycles during a divide -> stall_o=011111 for those cycles, then 001111 if the divide has not yet finished.
- Reset: rst_ni low mid-divide -> all outputs 0 next cycle, stall_cnt_o=0, FSM idle.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef logic [5:0] stall_mask_t;

  // Stage indices within a stall mask
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  // Nested masks: each hazard freezes its own stage and everything upstream
  localparam stall_mask_t STALL_NONE = 6'b000000;
  localparam stall_mask_t LOAD_USE   = 6'b000111;
  localparam stall_mask_t DIV        = 6'b001111;
  localparam stall_mask_t MEM        = 6'b011111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } div_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-information and stall-control bundle between the pipeline and the
// stall controller. Optional macro PIPE_DCACHE_STALL_EN adds the data-cache
// handshake signals.
interface pipe_stall_ctrl_if;
  logic        id_re1_i;
  logic [4:0]  id_raddr1_i;
  logic        id_re2_i;
  logic [4:0]  id_raddr2_i;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic        ex_is_load_i;
  logic        ex_div_start_i;
  logic        flush_i;
`ifdef PIPE_DCACHE_STALL_EN
  logic        mem_req_i;
  logic        mem_ack_i;
`endif
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        div_busy_o;
  logic        div_done_o;
  logic [31:0] stall_cnt_o;

  // Pipeline side: reports hazard information, receives stall/flush
  modport master (
    output id_re1_i, id_raddr1_i, id_re2_i, id_raddr2_i,
    output ex_we_i, ex_waddr_i, ex_is_load_i, ex_div_start_i, flush_i,
`ifdef PIPE_DCACHE_STALL_EN
    output mem_req_i, mem_ack_i,
`endif
    input  stall_o, flush_o, div_busy_o, div_done_o, stall_cnt_o
  );

  // Controller side
  modport slave (
    input  id_re1_i, id_raddr1_i, id_re2_i, id_raddr2_i,
    input  ex_we_i, ex_waddr_i, ex_is_load_i, ex_div_start_i, flush_i,
`ifdef PIPE_DCACHE_STALL_EN
    input  mem_req_i, mem_ack_i,
`endif
    output stall_o, flush_o, div_busy_o, div_done_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl_div_wait_fsm.sv
// Divide occupancy tracker: holds EX for DIV_LATENCY cycles, then pulses done.
//
// state  | meaning
// S_IDLE | no divide in flight; a start request begins one
// S_DIV  | counting down; stall while cnt!=0, done pulse when cnt==0
module div_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = $clog2(DIV_LATENCY)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic cancel,
  output logic div_stall,
  output logic div_busy,
  output logic div_done
);

  div_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  // State and countdown register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, countdown and outputs; cancel wins over everything
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_stall = 1'b0;
    div_done  = 1'b0;
    div_busy  = (state == S_DIV) | ((state == S_IDLE) & start);
    if (cancel) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            div_stall = 1'b1;
            state_n   = S_DIV;
            cnt_n     = CNT_W'(DIV_LATENCY - 1);
          end
        end
        S_DIV: begin
          if (cnt != '0) begin
            div_stall = 1'b1;
            cnt_n     = cnt - CNT_W'(1);
          end else begin
            div_done = 1'b1;
            state_n  = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, divide occupancy, optional
// data-cache wait (macro PIPE_DCACHE_STALL_EN) and exception flush.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 32,
  parameter int CNT_W       = $clog2(DIV_LATENCY)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  pipe_stall_ctrl_if.slave bus
);

  logic        load_use;
  logic        div_stall, div_busy, div_done;
  logic        mem_stall;
  stall_mask_t stall_raw, stall;
  logic [31:0] stall_cnt;

  div_wait_fsm #(
    .DIV_LATENCY(DIV_LATENCY),
    .CNT_W      (CNT_W)
  ) u_div (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .start    (bus.ex_div_start_i),
    .cancel   (bus.flush_i),
    .div_stall(div_stall),
    .div_busy (div_busy),
    .div_done (div_done)
  );

  // Load-use RAW: a load in EX writing a register ID is about to read
  always_comb begin
    load_use = bus.ex_is_load_i & bus.ex_we_i & (bus.ex_waddr_i != 5'd0) &
               ((bus.id_re1_i & (bus.id_raddr1_i == bus.ex_waddr_i)) |
                (bus.id_re2_i & (bus.id_raddr2_i == bus.ex_waddr_i)));
  end

  // Data-cache wait contribution; EX is frozen by it so the divider keeps counting
`ifdef PIPE_DCACHE_STALL_EN
  always_comb mem_stall = bus.mem_req_i & ~bus.mem_ack_i;
`else
  always_comb mem_stall = 1'b0;
`endif

  // Combine nested masks; flush overrides all stalls
  always_comb begin
    stall_raw = STALL_NONE;
    if (load_use)  stall_raw = stall_raw | LOAD_USE;
    if (div_stall) stall_raw = stall_raw | DIV;
    if (mem_stall) stall_raw = stall_raw | MEM;
    stall = bus.flush_i ? STALL_NONE : stall_raw;
  end

  // Saturating stalled-cycle counter; flush does not clear it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if ((stall != STALL_NONE) && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Outputs are held at zero for the whole time reset is asserted
  always_comb begin
    bus.stall_o     = rst_ni ? stall : STALL_NONE;
    bus.flush_o     = rst_ni & bus.flush_i;
    bus.div_busy_o  = rst_ni & div_busy;
    bus.div_done_o  = rst_ni & div_done;
    bus.stall_cnt_o = rst_ni ? stall_cnt : 32'd0;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl with DIV_LATENCY=4.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(.DIV_LATENCY(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  int          id_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          vec_id = 0;
  logic [31:0] model_cnt = 32'd0;
`ifdef PIPE_DCACHE_STALL_EN
  logic        mem_req = 1'b0;
  logic        mem_ack = 1'b0;
`endif

  // Apply one cycle of inputs and record what the DUT must show for it
  task automatic cyc(input bit rst, input bit div, input bit fl,
                     input bit ld, input bit we, input logic [4:0] wa,
                     input bit re1, input logic [4:0] a1,
                     input bit re2, input logic [4:0] a2,
                     input logic [5:0] e_st, input bit e_fl,
                     input bit e_busy, input bit e_done);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n              = rst;
    bus.ex_div_start_i = div;
    bus.flush_i        = fl;
    bus.ex_is_load_i   = ld;
    bus.ex_we_i        = we;
    bus.ex_waddr_i     = wa;
    bus.id_re1_i       = re1;
    bus.id_raddr1_i    = a1;
    bus.id_re2_i       = re2;
    bus.id_raddr2_i    = a2;
`ifdef PIPE_DCACHE_STALL_EN
    bus.mem_req_i      = mem_req;
    bus.mem_ack_i      = mem_ack;
`endif
    e.stall = e_st;
    e.flush = e_fl;
    e.busy  = e_busy;
    e.done  = e_done;
    e.cnt   = rst ? model_cnt : 32'd0;
    exp_q.push_back(e);
    id_q.push_back(vec_id);
    vec_id++;
    if (!rst) model_cnt = 32'd0;
    else if (e_st != 6'd0 && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
  endtask

  // Cycle with no register-file hazard information
  task automatic dv(input bit rst, input bit div, input bit fl,
                    input logic [5:0] e_st, input bit e_fl,
                    input bit e_busy, input bit e_done);
    cyc(rst, div, fl, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,
        e_st, e_fl, e_busy, e_done);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  initial begin
    exp_t e;
    int   id;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        n_vec++;
        if (bus.stall_o !== e.stall || bus.flush_o !== e.flush ||
            bus.div_busy_o !== e.busy || bus.div_done_o !== e.done ||
            bus.stall_cnt_o !== e.cnt) begin
          n_err++;
          $display("FAIL vec%0d: got stall=%b flush=%b busy=%b done=%b cnt=%0d, want stall=%b flush=%b busy=%b done=%b cnt=%0d",
                   id, bus.stall_o, bus.flush_o, bus.div_busy_o, bus.div_done_o,
                   bus.stall_cnt_o, e.stall, e.flush, e.busy, e.done, e.cnt);
        end
      end
    end
  end

  localparam logic [5:0] Z  = 6'b000000;
  localparam logic [5:0] LU = 6'b000111;
  localparam logic [5:0] DV = 6'b001111;
`ifdef PIPE_DCACHE_STALL_EN
  localparam logic [5:0] MM = 6'b011111;
`endif

  initial begin
    bus.ex_div_start_i = 1'b0; bus.flush_i = 1'b0; bus.ex_is_load_i = 1'b0;
    bus.ex_we_i = 1'b0; bus.ex_waddr_i = 5'd0; bus.id_re1_i = 1'b0;
    bus.id_raddr1_i = 5'd0; bus.id_re2_i = 1'b0; bus.id_raddr2_i = 5'd0;
`ifdef PIPE_DCACHE_STALL_EN
    bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;
`endif
    // Reset with hazards present: everything forced low
    cyc(0, 1, 0, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, Z, 0, 0, 0);
    dv(1, 0, 0, Z, 0, 0, 0);
    // Load to $5, ID reads $5 on re2: one stall, then bubble clears it
    cyc(1, 0, 0, 1, 1, 5'd5, 0, 5'd0, 1, 5'd5, LU, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd5, Z, 0, 0, 0);
    // Load to $0 never stalls; non-writing load never stalls
    cyc(1, 0, 0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, Z, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 5'd7, 1, 5'd7, 0, 5'd0, Z, 0, 0, 0);
    // re1 match
    cyc(1, 0, 0, 1, 1, 5'd9, 1, 5'd9, 0, 5'd9, LU, 0, 0, 0);
    // Divide T..T+3 stall, done at T+4, back-to-back restart at T+5
    repeat (4) dv(1, 1, 0, DV, 0, 1, 0);
    dv(1, 1, 0, Z, 0, 1, 1);
    repeat (4) dv(1, 1, 0, DV, 0, 1, 0);
    dv(1, 1, 0, Z, 0, 1, 1);
    dv(1, 0, 0, Z, 0, 0, 0);
    // Flush at T+2 of a divide: cancelled, no done pulse
    repeat (2) dv(1, 1, 0, DV, 0, 1, 0);
    dv(1, 1, 1, Z, 1, 1, 0);
    repeat (4) dv(1, 0, 0, Z, 0, 0, 0);
    // Load-use and divide start together: DIV mask wins
    cyc(1, 1, 0, 1, 1, 5'd3, 1, 5'd3, 0, 5'd0, DV, 0, 1, 0);
    repeat (3) dv(1, 1, 0, DV, 0, 1, 0);
    dv(1, 1, 0, Z, 0, 1, 1);
    dv(1, 0, 0, Z, 0, 0, 0);
    // Flush with divide start in idle: divide does not begin
    dv(1, 1, 1, Z, 1, 1, 0);
    dv(1, 0, 0, Z, 0, 0, 0);
    dv(1, 0, 0, Z, 0, 0, 0);
    // Reset mid-divide, then a fresh divide takes the full latency
    repeat (2) dv(1, 1, 0, DV, 0, 1, 0);
    dv(0, 1, 0, Z, 0, 0, 0);
    repeat (4) dv(1, 1, 0, DV, 0, 1, 0);
    dv(1, 1, 0, Z, 0, 1, 1);
    dv(1, 0, 0, Z, 0, 0, 0);
`ifdef PIPE_DCACHE_STALL_EN
    // Cache miss for 3 cycles during a divide; counter keeps running
    mem_req = 1'b1; mem_ack = 1'b0;
    repeat (3) dv(1, 1, 0, MM, 0, 1, 0);
    mem_req = 1'b1; mem_ack = 1'b1;
    dv(1, 1, 0, DV, 0, 1, 0);
    mem_req = 1'b0; mem_ack = 1'b0;
    dv(1, 1, 0, Z, 0, 1, 1);
    dv(1, 0, 0, Z, 0, 0, 0);
    // Flush overrides a cache stall
    mem_req = 1'b1;
    dv(1, 0, 1, Z, 1, 0, 0);
    dv(1, 0, 0, MM, 0, 0, 0);
    mem_req = 1'b0;
    dv(1, 0, 0, Z, 0, 0, 0);
`endif
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
